// File: rtl/fmc_bram2axil.sv
// FMC BRAM-port to AXI4-Lite master bridge: each accepted access becomes one single-beat AXI transaction.
// Optional AXI error-response counter is built only when FMC_BRAM2AXIL_ERR_CNT_EN is defined.
module fmc_bram2axil #(
  parameter int C_ADDR_WIDTH     = 12,
  parameter int C_DATA_WIDTH     = 16,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_AXI_BASE_ADDR = 32'h4000_0000
) (
  input  logic                        bram_clk,
  input  logic                        bram_rst,
  input  logic [C_ADDR_WIDTH-1:0]     bram_addr,
  input  logic                        bram_en,
  input  logic [C_DATA_WIDTH/8-1:0]   bram_we,
  input  logic [C_DATA_WIDTH-1:0]     bram_din,
  output logic [C_DATA_WIDTH-1:0]     bram_dout,
  output logic                        bram_busy,
  output logic [15:0]                 err_cnt,

  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [31:0]                 m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [31:0]                 m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  // state | meaning
  // IDLE  | waiting for bram_en
  // WR    | awvalid and/or wvalid still outstanding
  // WB    | bready high, waiting for bvalid
  // RA    | arvalid high, waiting for arready
  // RD    | rready high, waiting for rvalid
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_RA   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;

  localparam int ADDR_SHIFT = (C_DATA_WIDTH == 32) ? 2 : 1;

  logic [2:0]                  state;
  logic [C_AXI_ADDR_WIDTH-1:0] byte_addr;
  logic [C_AXI_ADDR_WIDTH-1:0] word_addr;
  logic [31:0]                 wdata_nxt;
  logic [3:0]                  wstrb_nxt;
  logic [C_DATA_WIDTH-1:0]     rdata_lane;
  logic                        aw_done;
  logic                        w_done;

  assign byte_addr = C_AXI_BASE_ADDR + (C_AXI_ADDR_WIDTH'(bram_addr) << ADDR_SHIFT);
  assign word_addr = byte_addr & ~C_AXI_ADDR_WIDTH'(3);

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign bram_busy    = (state != S_IDLE);

  // A channel counts as done once its valid has already dropped or is handshaking now.
  assign aw_done = ~m_axi_awvalid | m_axi_awready;
  assign w_done  = ~m_axi_wvalid  | m_axi_wready;

  if (C_DATA_WIDTH == 16) begin : g_dw16
    logic lane;

    always_ff @(posedge bram_clk) begin
      if (bram_rst) begin
        lane <= 1'b0;
      end else if (state == S_IDLE && bram_en) begin
        lane <= byte_addr[1];
      end
    end

    assign wdata_nxt  = {bram_din, bram_din};
    assign wstrb_nxt  = byte_addr[1] ? {bram_we, 2'b00} : {2'b00, bram_we};
    assign rdata_lane = lane ? m_axi_rdata[31:16] : m_axi_rdata[15:0];
  end else begin : g_dw32
    assign wdata_nxt  = bram_din;
    assign wstrb_nxt  = bram_we;
    assign rdata_lane = m_axi_rdata;
  end

  always_ff @(posedge bram_clk) begin
    if (bram_rst) begin
      state         <= S_IDLE;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      bram_dout     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bram_en) begin
            if (|bram_we) begin
              m_axi_awaddr  <= word_addr;
              m_axi_wdata   <= wdata_nxt;
              m_axi_wstrb   <= wstrb_nxt;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= S_WR;
            end else begin
              m_axi_araddr  <= word_addr;
              m_axi_arvalid <= 1'b1;
              state         <= S_RA;
            end
          end
        end
        S_WR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= S_WB;
          end
        end
        S_WB: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_RA: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_RD;
          end
        end
        S_RD: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            bram_dout    <= rdata_lane;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FMC_BRAM2AXIL_ERR_CNT_EN
  logic [15:0] err_q;
  logic        err_evt;
  logic        unused_resp;

  // SLVERR and DECERR both have bit 1 set; EXOKAY is not an error.
  assign err_evt = (m_axi_bvalid && m_axi_bready && m_axi_bresp[1]) ||
                   (m_axi_rvalid && m_axi_rready && m_axi_rresp[1]);

  always_ff @(posedge bram_clk) begin
    if (bram_rst) begin
      err_q <= 16'h0000;
    end else if (err_evt && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt     = err_q;
  assign unused_resp = &{1'b0, m_axi_bresp[0], m_axi_rresp[0]};
`else
  logic unused_resp;

  assign err_cnt     = 16'h0000;
  assign unused_resp = &{1'b0, m_axi_bresp, m_axi_rresp};
`endif

endmodule

// File: tb/tb_fmc_bram2axil.sv
// Directed bench for fmc_bram2axil (16-bit default build) with a configurable-latency AXI4-Lite slave.
module tb_fmc_bram2axil;

  logic        bram_clk = 1'b0;
  logic        bram_rst;
  logic [11:0] bram_addr;
  logic        bram_en;
  logic [1:0]  bram_we;
  logic [15:0] bram_din;
  logic [15:0] bram_dout;
  logic        bram_busy;
  logic [15:0] err_cnt;

  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  always #5 bram_clk = ~bram_clk;

  fmc_bram2axil dut (
    .bram_clk      (bram_clk),
    .bram_rst      (bram_rst),
    .bram_addr     (bram_addr),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_din      (bram_din),
    .bram_dout     (bram_dout),
    .bram_busy     (bram_busy),
    .err_cnt       (err_cnt),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  int total = 0;
  int bad   = 0;

  // slave model: ready asserts after a programmable number of valid-wait cycles
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0]  resp_cfg  = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_seen, w_seen;
  int          aw_count = 0, ar_count = 0;
  logic        aw_hs, w_hs, ar_hs;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid  && (w_cnt  >= w_dly);
  assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_dly);
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;

  always @(posedge bram_clk) begin
    if (bram_rst) begin
      aw_cnt       <= 0;
      w_cnt        <= 0;
      ar_cnt       <= 0;
      aw_seen      <= 1'b0;
      w_seen       <= 1'b0;
      m_axi_bvalid <= 1'b0;
      m_axi_bresp  <= 2'b00;
      m_axi_rvalid <= 1'b0;
      m_axi_rdata  <= 32'h0;
      m_axi_rresp  <= 2'b00;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid  && !m_axi_wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if ((aw_seen || aw_hs) && (w_seen || w_hs) && !m_axi_bvalid) begin
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= resp_cfg;
        aw_seen      <= 1'b0;
        w_seen       <= 1'b0;
      end else begin
        if (aw_hs) aw_seen <= 1'b1;
        if (w_hs)  w_seen  <= 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (ar_hs) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= rdata_cfg;
        m_axi_rresp  <= resp_cfg;
      end
    end
  end

  always @(posedge bram_clk) begin
    if (aw_hs) aw_count <= aw_count + 1;
    if (ar_hs) ar_count <= ar_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge of cycle 1.
  task automatic issue(input logic [11:0] a, input logic [1:0] we, input logic [15:0] d);
    bram_addr = a;
    bram_we   = we;
    bram_din  = d;
    bram_en   = 1'b1;
    @(negedge bram_clk);
    bram_en   = 1'b0;
    bram_we   = 2'b00;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (bram_busy && n < max) begin
      @(negedge bram_clk);
      n++;
    end
    chk(tag, {31'b0, bram_busy}, 32'd0);
  endtask

  int          a0, r0;
  logic [15:0] exp_err;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bram_rst  = 1'b1;
    bram_en   = 1'b0;
    bram_addr = 12'h000;
    bram_we   = 2'b00;
    bram_din  = 16'h0000;
    repeat (3) @(negedge bram_clk);

    chk("rst_busy",    {31'b0, bram_busy},     32'd0);
    chk("rst_dout",    {16'b0, bram_dout},     32'd0);
    chk("rst_err",     {16'b0, err_cnt},       32'd0);
    chk("rst_awvalid", {31'b0, m_axi_awvalid}, 32'd0);
    chk("rst_wvalid",  {31'b0, m_axi_wvalid},  32'd0);
    chk("rst_arvalid", {31'b0, m_axi_arvalid}, 32'd0);
    chk("rst_bready",  {31'b0, m_axi_bready},  32'd0);
    chk("rst_rready",  {31'b0, m_axi_rready},  32'd0);
    chk("rst_awaddr",  m_axi_awaddr,           32'd0);
    chk("rst_araddr",  m_axi_araddr,           32'd0);
    chk("rst_wdata",   m_axi_wdata,            32'd0);
    chk("rst_wstrb",   {28'b0, m_axi_wstrb},   32'd0);
    bram_rst = 1'b0;
    @(negedge bram_clk);

    // zero-wait write, upper lane
    issue(12'h003, 2'b11, 16'hA5C3);
    chk("wr_c1_busy",    {31'b0, bram_busy},     32'd1);
    chk("wr_c1_awvalid", {31'b0, m_axi_awvalid}, 32'd1);
    chk("wr_c1_wvalid",  {31'b0, m_axi_wvalid},  32'd1);
    chk("wr_awaddr",     m_axi_awaddr,           32'h4000_0004);
    chk("wr_wdata",      m_axi_wdata,            32'hA5C3_A5C3);
    chk("wr_wstrb",      {28'b0, m_axi_wstrb},   32'hC);
    chk("wr_awprot",     {29'b0, m_axi_awprot},  32'd0);
    @(negedge bram_clk);
    chk("wr_c2_busy",    {31'b0, bram_busy},     32'd1);
    chk("wr_c2_bready",  {31'b0, m_axi_bready},  32'd1);
    chk("wr_c2_awvalid", {31'b0, m_axi_awvalid}, 32'd0);
    @(negedge bram_clk);
    chk("wr_c3_busy",    {31'b0, bram_busy},     32'd0);

    // zero-wait reads, lower then upper lane of the same word
    rdata_cfg = 32'h1234_5678;
    issue(12'h002, 2'b00, 16'h0000);
    chk("rd2_c1_busy",    {31'b0, bram_busy},     32'd1);
    chk("rd2_c1_arvalid", {31'b0, m_axi_arvalid}, 32'd1);
    chk("rd2_araddr",     m_axi_araddr,           32'h4000_0004);
    chk("rd2_arprot",     {29'b0, m_axi_arprot},  32'd0);
    @(negedge bram_clk);
    chk("rd2_c2_busy",    {31'b0, bram_busy},     32'd1);
    chk("rd2_c2_rready",  {31'b0, m_axi_rready},  32'd1);
    @(negedge bram_clk);
    chk("rd2_c3_busy",    {31'b0, bram_busy},     32'd0);
    chk("rd2_dout",       {16'b0, bram_dout},     32'h5678);
    issue(12'h003, 2'b00, 16'h0000);
    chk("rd3_araddr",     m_axi_araddr,           32'h4000_0004);
    repeat (2) @(negedge bram_clk);
    chk("rd3_c3_busy",    {31'b0, bram_busy},     32'd0);
    chk("rd3_dout",       {16'b0, bram_dout},     32'h1234);

    // write with awready delayed four cycles, wready immediate
    aw_dly = 4;
    issue(12'h000, 2'b01, 16'h00BE);
    chk("wd_c1_awvalid", {31'b0, m_axi_awvalid}, 32'd1);
    chk("wd_c1_wvalid",  {31'b0, m_axi_wvalid},  32'd1);
    chk("wd_awaddr",     m_axi_awaddr,           32'h4000_0000);
    chk("wd_wdata",      m_axi_wdata,            32'h00BE_00BE);
    chk("wd_wstrb",      {28'b0, m_axi_wstrb},   32'h1);
    for (int c = 2; c <= 5; c++) begin
      @(negedge bram_clk);
      chk($sformatf("wd_c%0d_awvalid", c), {31'b0, m_axi_awvalid}, 32'd1);
      chk($sformatf("wd_c%0d_wvalid", c),  {31'b0, m_axi_wvalid},  32'd0);
      chk($sformatf("wd_c%0d_bready", c),  {31'b0, m_axi_bready},  32'd0);
    end
    @(negedge bram_clk);
    chk("wd_c6_awvalid", {31'b0, m_axi_awvalid}, 32'd0);
    chk("wd_c6_bready",  {31'b0, m_axi_bready},  32'd1);
    @(negedge bram_clk);
    chk("wd_c7_busy",    {31'b0, bram_busy},     32'd0);
    chk("wd_dout_kept",  {16'b0, bram_dout},     32'h1234);
    aw_dly = 0;

    // bram_en pulsed while a read is outstanding
    ar_dly    = 2;
    rdata_cfg = 32'hCAFE_F00D;
    a0 = aw_count;
    r0 = ar_count;
    issue(12'h010, 2'b00, 16'h0000);
    chk("bz_araddr", m_axi_araddr, 32'h4000_0020);
    bram_addr = 12'h020;
    bram_we   = 2'b11;
    bram_din  = 16'hFFFF;
    bram_en   = 1'b1;
    repeat (2) @(negedge bram_clk);
    bram_en   = 1'b0;
    bram_we   = 2'b00;
    wait_idle(20, "bz_idle");
    chk("bz_dout",     {16'b0, bram_dout}, 32'hF00D);
    repeat (3) @(negedge bram_clk);
    chk("bz_busy_after", {31'b0, bram_busy}, 32'd0);
    chk("bz_ar_count", ar_count - r0, 32'd1);
    chk("bz_aw_count", aw_count - a0, 32'd0);
    ar_dly = 0;

    // three reads answered with SLVERR
    resp_cfg  = 2'b10;
    rdata_cfg = 32'h9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      issue(12'h005, 2'b00, 16'h0000);
      wait_idle(10, $sformatf("er%0d_idle", i));
      chk($sformatf("er%0d_dout", i), {16'b0, bram_dout}, 32'h9ABC);
    end
`ifdef FMC_BRAM2AXIL_ERR_CNT_EN
    exp_err = 16'd3;
`else
    exp_err = 16'd0;
`endif
    chk("er_cnt", {16'b0, err_cnt}, {16'b0, exp_err});
    resp_cfg = 2'b00;

    // reset while arvalid is waiting on arready
    ar_dly = 1000;
    issue(12'h007, 2'b00, 16'h0000);
    chk("rr_c1_arvalid", {31'b0, m_axi_arvalid}, 32'd1);
    @(negedge bram_clk);
    chk("rr_c2_arvalid", {31'b0, m_axi_arvalid}, 32'd1);
    chk("rr_c2_arready", {31'b0, m_axi_arready}, 32'd0);
    bram_rst = 1'b1;
    @(negedge bram_clk);
    chk("rr_arvalid", {31'b0, m_axi_arvalid}, 32'd0);
    chk("rr_busy",    {31'b0, bram_busy},     32'd0);
    chk("rr_dout",    {16'b0, bram_dout},     32'd0);
    chk("rr_err",     {16'b0, err_cnt},       32'd0);
    chk("rr_araddr",  m_axi_araddr,           32'd0);
    bram_rst  = 1'b0;
    ar_dly    = 0;
    rdata_cfg = 32'h1357_2468;
    @(negedge bram_clk);
    issue(12'h007, 2'b00, 16'h0000);
    chk("rr2_araddr", m_axi_araddr, 32'h4000_000C);
    wait_idle(10, "rr2_idle");
    chk("rr2_dout",   {16'b0, bram_dout}, 32'h1357);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmc_bram2axil.md
# fmc_bram2axil

Bridge between the FMC slave's BRAM-style port and an AXI4-Lite master. Each accepted BRAM access becomes exactly one AXI4-Lite single-beat transaction. The block sits directly downstream of the FMC slave interface and drives the on-chip AXI register fabric. `bram_busy` is returned upstream for use as the FMC wait source.

## Interface
Parameters:
- `C_ADDR_WIDTH`, 12, word address width of the BRAM port.
- `C_DATA_WIDTH`, 16, BRAM data width; legal values 16 or 32.
- `C_AXI_ADDR_WIDTH`, 32, AXI address width.
- `C_AXI_BASE_ADDR`, 32'h4000_0000, byte base address added to every access.

Ports (one clock; reset is synchronous and active-high):
- `bram_clk`  in  1  sole clock; AXI side is also synchronous to it.
- `bram_rst`  in  1  synchronous, active-high reset.
- `bram_addr`  in  C_ADDR_WIDTH  word address.
- `bram_en`  in  1  access request.
- `bram_we`  in  C_DATA_WIDTH/8  byte write enables; all-zero means read.
- `bram_din`  in  C_DATA_WIDTH  write data.
- `bram_dout`  out  C_DATA_WIDTH  registered read data.
- `bram_busy`  out  1  transaction in flight.
- `err_cnt`  out  16  AXI error response count.
- `m_axi_awaddr/awprot/awvalid/awready`  standard AXI4-Lite write-address channel; `awprot` = 3'b000.
- `m_axi_wdata[31:0]/wstrb[3:0]/wvalid/wready`  standard write-data channel.
- `m_axi_bresp[1:0]/bvalid/bready`  standard write-response channel.
- `m_axi_araddr/arprot/arvalid/arready`  standard read-address channel; `arprot` = 3'b000.
- `m_axi_rdata[31:0]/rresp[1:0]/rvalid/rready`  standard read-data channel.

## Operation
- States: IDLE, WR, WB, RA, RD.
- Accept in IDLE when `bram_en`=1:
  - Latch address, data and strobes.
  - Go to WR if `|bram_we`, else RA.
- Requests with `bram_en`=1 outside IDLE are ignored, never queued.
- Byte address = `C_AXI_BASE_ADDR + (bram_addr << log2(C_DATA_WIDTH/8))`, truncated to `C_AXI_ADDR_WIDTH`.
  - AXI address is that value with bits [1:0] cleared.
- Lane mapping when `C_DATA_WIDTH`=16:
  - `lane` = byte address bit 1.
  - `wdata` = {din,din}.
  - `wstrb` = lane ? {we,2'b00} : {2'b00,we}.
  - Read returns `rdata[31:16]` if lane, else `rdata[15:0]`.
- Lane mapping when `C_DATA_WIDTH`=32: direct mapping.
- WR:
  - `awvalid` and `wvalid` rise together.
  - Each drops independently after its own handshake.
  - Go to WB once both handshakes are done; this includes both completing in the same cycle.
- WB: `bready`=1; on `bvalid` go to IDLE.
- RA: `arvalid`=1 until `arready`, then go to RD.
- RD: `rready`=1; on `rvalid`, load lane-selected data into `bram_dout` and go to IDLE.
- `bram_dout` holds its value until the next completed read; writes never change it.
- Response `resp` != OKAY: the transaction still completes normally, and read data is passed through unchanged.

## Timing
- Reset values:
  - State IDLE.
  - All `*valid`, `bready`, `rready` = 0.
  - `bram_busy` = 0, `bram_dout` = 0, `err_cnt` = 0.
  - AXI address/data outputs = 0.
- Acceptance at cycle 0:
  - Cycle 1: `bram_busy`=1 and the first AXI `*valid`=1.
- Final handshake (`bvalid&bready` or `rvalid&rready`) at cycle N:
  - Cycle N+1: `bram_busy`=0, `bram_dout` valid (reads), state IDLE.
  - A new request is acceptable in cycle N+1.
- Minimum latency with zero-wait slave:
  - Write: 3 cycles from `bram_en` to `busy` low.
  - Read: 3 cycles from `bram_en` to `busy` low.
- `*valid` never deasserts before its handshake (AXI rule).
- Reset mid-transaction:
  - Immediate return to reset values.
  - The AXI slave must share `bram_rst`.

## Configuration
- Macro `FMC_BRAM2AXIL_ERR_CNT_EN`.
- Defined:
  - `err_cnt` increments on each `bresp` or `rresp` of SLVERR/DECERR at its handshake.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: `err_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Write, 16-bit config, `bram_addr`=12'h003, `we`=2'b11, `din`=16'hA5C3, zero-wait slave:
  - `awaddr`=32'h4000_0004, `wdata`=32'hA5C3_A5C3, `wstrb`=4'b1100.
  - `busy` high cycles 1-2, low cycle 3.
- Read `bram_addr`=12'h002, slave `rdata`=32'h1234_5678:
  - `araddr`=32'h4000_0004, `bram_dout`=16'h5678.
  - Same read at 12'h003 gives 16'h1234.
- Write with `awready` delayed 4 cycles and `wready` immediate:
  - `wvalid` drops after 1 cycle, `awvalid` held 5 cycles.
  - `bready` asserted only after both handshakes.
- `bram_en` pulsed while busy:
  - Ignored.
  - Exactly one AXI transaction observed.
- Read returning `rresp`=2'b10 three times:
  - With macro, `err_cnt`=3.
  - Without macro, `err_cnt`=0.
  - `bram_dout` = returned data in both cases.
- `bram_rst` asserted while `arvalid`=1 and `arready`=0:
  - Next cycle `arvalid`=0, `busy`=0, `bram_dout`=0.
  - A following read completes normally.
